// File: rtl/sipo_rx.sv
// -----------------------------------------------------------------------------
// sipo_rx -- serial-to-parallel frame receiver
//
// Reassembles WIDTH-bit words from a strobed, MSB-first serial bit stream, as
// produced by a left-shifting parallel-load serializer. A completed word is
// presented on a one-entry output register with a valid/ready handshake. A
// sticky overrun flag records words that were dropped because the output
// register was still occupied.
//
// Parameters
//   WIDTH       word length in bits (WIDTH >= 2)
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous reset, active-low
//   sin         serial data bit, sampled only while sin_en=1
//   sin_en      bit strobe, one bit accepted per strobed cycle
//   sof         start of frame, qualified by sin_en; marks the MSB of a frame
//   dout        received word, first received bit in dout[WIDTH-1]
//   dout_valid  dout holds an unconsumed word
//   dout_ready  consumer accepts dout while dout_valid=1
//   overrun     sticky: a completed word was dropped
//   clr_ovr     clears overrun (a same-cycle drop takes priority)
//   busy        a frame is partially received
// -----------------------------------------------------------------------------
module sipo_rx #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             sof,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
    input  logic             clr_ovr,
    output logic             busy
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] dout_q;
    logic             dout_valid_q;
    logic             overrun_q;

    logic [WIDTH-1:0] shift_d;
    logic             word_done;
    logic             can_load;
    logic             drop;

    always_comb begin
        shift_d   = {shreg_q[WIDTH-2:0], sin};
        // Completing bit: last bit of a frame, not a resync strobe.
        word_done = sin_en && !sof && (state_q == SHIFT) && (cnt_q == CNT_LAST);
        // The output register can take a new word if it is empty or is being
        // consumed in this same cycle.
        can_load  = !dout_valid_q || dout_ready;
        drop      = word_done && !can_load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (sin_en) begin
                case (state_q)
                    IDLE: begin
                        if (sof) begin
                            shreg_q <= shift_d;
                            cnt_q   <= CNT_ONE;
                            state_q <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (sof) begin
                            // Resync: the partial word is abandoned and this
                            // bit becomes the MSB of a new frame.
                            shreg_q <= shift_d;
                            cnt_q   <= CNT_ONE;
                        end else if (cnt_q == CNT_LAST) begin
                            shreg_q <= shift_d;
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            shreg_q <= shift_d;
                            cnt_q   <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end

            if (word_done && can_load) begin
                dout_q       <= shift_d;
                dout_valid_q <= 1'b1;
            end else if (dout_valid_q && dout_ready) begin
                dout_valid_q <= 1'b0;
            end

            if (drop) begin
                overrun_q <= 1'b1;
            end else if (clr_ovr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q == SHIFT);

endmodule

// File: tb/tb_sipo_rx.sv
module tb_sipo_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sin, sin_en, sof, dout_ready, clr_ovr;
    logic [3:0] dout;
    logic       dout_valid, overrun, busy;

    int n_checks = 0;
    int n_fail   = 0;

    sipo_rx #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sin        (sin),
        .sin_en     (sin_en),
        .sof        (sof),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overrun    (overrun),
        .clr_ovr    (clr_ovr),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Present one strobed bit at a negedge; return at the following negedge,
    // after the sampling posedge.
    task automatic send_bit(input logic b, input logic s);
        sin    = b;
        sof    = s;
        sin_en = 1'b1;
        @(negedge clk);
        sin_en = 1'b0;
        sof    = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sin        = 1'($urandom);
            sin_en     = 1'($urandom);
            sof        = 1'($urandom);
            dout_ready = 1'($urandom);
            clr_ovr    = 1'($urandom);
            @(negedge clk);
        end
        sin = 0; sin_en = 0; sof = 0; dout_ready = 0; clr_ovr = 0;
        rst_n = 1'b1;
        idle_cycle();
        n_checks++; if (dout !== 4'b0000) begin n_fail++; $display("FAIL rst_dout got %b exp 0000", dout); end
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", dout_valid); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun got %b exp 0", overrun); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
    endtask

    task automatic test_basic();
        logic [3:0] bits;
        bits = 4'b1011;
        dout_ready = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            send_bit(bits[i], i == 3);
            if (i > 0) begin
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy bit%0d got %b exp 1", 3 - i, busy); end
                n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid bit%0d got %b exp 0", 3 - i, dout_valid); end
            end
        end
        n_checks++; if (dout !== 4'b1011) begin n_fail++; $display("FAIL basic_dout got %b exp 1011", dout); end
        n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b exp 1", dout_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end got %b exp 0", busy); end
        idle_cycle();
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_1cyc got %b exp 0", dout_valid); end
        n_checks++; if (dout !== 4'b1011) begin n_fail++; $display("FAIL basic_dout_hold got %b exp 1011", dout); end
    endtask

    task automatic test_gaps();
        logic [3:0] bits;
        bits = 4'b1011;
        dout_ready = 1'b1;
        // A non-sof strobe in IDLE must be ignored.
        send_bit(1'b1, 1'b0);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL gap_idle_ignore busy got %b exp 0", busy); end
        for (int i = 3; i >= 0; i--) begin
            send_bit(bits[i], i == 3);
            if (i > 0) begin
                for (int g = 0; g < (i % 3) + 1; g++) begin
                    sin = ~sin;
                    idle_cycle();
                    n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL gap_early_valid got %b exp 0", dout_valid); end
                end
            end
        end
        n_checks++; if (dout !== 4'b1011) begin n_fail++; $display("FAIL gap_dout got %b exp 1011", dout); end
        n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL gap_valid got %b exp 1", dout_valid); end
        idle_cycle();
    endtask

    task automatic test_overrun();
        logic [3:0] a, b;
        a = 4'b1011;
        b = 4'b0110;
        dout_ready = 1'b0;
        for (int i = 3; i >= 0; i--) send_bit(a[i], i == 3);
        n_checks++; if (dout !== 4'b1011 || dout_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_first got %b/%b exp 1011/1", dout, dout_valid); end
        for (int i = 3; i >= 0; i--) begin
            send_bit(b[i], i == 3);
            n_checks++; if (dout !== 4'b1011) begin n_fail++; $display("FAIL ovr_stable got %b exp 1011", dout); end
        end
        n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid got %b exp 1", dout_valid); end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set got %b exp 1", overrun); end
        clr_ovr = 1'b1;
        idle_cycle();
        clr_ovr = 1'b0;
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got %b exp 0", overrun); end
        n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid_after_clr got %b exp 1", dout_valid); end
        // Drop coinciding with clr_ovr: the set wins.
        for (int i = 3; i >= 0; i--) begin
            if (i == 0) clr_ovr = 1'b1;
            send_bit(b[i], i == 3);
        end
        clr_ovr = 1'b0;
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set_wins got %b exp 1", overrun); end
        clr_ovr = 1'b1;
        idle_cycle();
        clr_ovr = 1'b0;
        dout_ready = 1'b1;
        idle_cycle();
        dout_ready = 1'b0;
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_consume got %b exp 0", dout_valid); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear2 got %b exp 0", overrun); end
    endtask

    task automatic test_simultaneous();
        logic [3:0] a, b;
        a = 4'b1011;
        b = 4'b0110;
        dout_ready = 1'b0;
        for (int i = 3; i >= 0; i--) send_bit(a[i], i == 3);
        for (int i = 3; i >= 0; i--) begin
            if (i == 0) dout_ready = 1'b1;
            send_bit(b[i], i == 3);
        end
        n_checks++; if (dout !== 4'b0110) begin n_fail++; $display("FAIL simul_dout got %b exp 0110", dout); end
        n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL simul_valid got %b exp 1", dout_valid); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL simul_overrun got %b exp 0", overrun); end
        idle_cycle();
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL simul_consume got %b exp 0", dout_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bits;
        bits = 8'b1100_0011;
        dout_ready = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            send_bit(bits[i], (i == 7) || (i == 3));
            if (i == 4) begin
                n_checks++; if (dout !== 4'b1100 || dout_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first got %b/%b exp 1100/1", dout, dout_valid); end
            end
        end
        n_checks++; if (dout !== 4'b0011 || dout_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second got %b/%b exp 0011/1", dout, dout_valid); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun got %b exp 0", overrun); end
        idle_cycle();
    endtask

    task automatic test_resync();
        logic [5:0] s1;
        logic [6:0] s2;
        logic [5:0] f1;
        logic [6:0] f2;
        dout_ready = 1'b1;
        // 1,1 aborted by a sof that starts frame 0010.
        s1 = 6'b110000; f1 = 6'b100000;
        s1 = 6'b11_0010; f1 = 6'b10_1000;
        for (int i = 5; i >= 0; i--) begin
            send_bit(s1[i], f1[i]);
            if (i > 0) begin
                n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL resync_early_valid got %b exp 0", dout_valid); end
            end
        end
        n_checks++; if (dout !== 4'b0010 || dout_valid !== 1'b1) begin n_fail++; $display("FAIL resync_dout got %b/%b exp 0010/1", dout, dout_valid); end
        // Resync landing on the would-be completing bit: 1,1,1 then sof 0,1,0,1.
        s2 = 7'b111_0101; f2 = 7'b100_1000;
        for (int i = 6; i >= 0; i--) begin
            send_bit(s2[i], f2[i]);
            if (i > 0) begin
                n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL resync_last_early got %b exp 0", dout_valid); end
            end
        end
        n_checks++; if (dout !== 4'b0101 || dout_valid !== 1'b1) begin n_fail++; $display("FAIL resync_last_dout got %b/%b exp 0101/1", dout, dout_valid); end
        idle_cycle();
    endtask

    task automatic test_reset_mid();
        logic [3:0] c;
        dout_ready = 1'b0;
        c = 4'b1111;
        for (int i = 3; i >= 0; i--) send_bit(c[i], i == 3);
        c = 4'b0000;
        for (int i = 3; i >= 0; i--) send_bit(c[i], i == 3);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        n_checks++; if (busy !== 1'b1 || overrun !== 1'b1 || dout_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre got busy%b ovr%b vld%b exp 1/1/1", busy, overrun, dout_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (dout !== 4'b0000 || dout_valid !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_async got %b/%b/%b/%b exp 0000/0/0/0", dout, dout_valid, overrun, busy); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dout_ready = 1'b1;
        c = 4'b1001;
        for (int i = 3; i >= 0; i--) send_bit(c[i], i == 3);
        n_checks++; if (dout !== 4'b1001 || dout_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_next got %b/%b exp 1001/1", dout, dout_valid); end
        idle_cycle();
    endtask

    initial begin
        sin = 0; sin_en = 0; sof = 0; dout_ready = 0; clr_ovr = 0; rst_n = 0;
        test_reset();
        test_basic();
        test_gaps();
        test_overrun();
        test_simultaneous();
        test_back_to_back();
        test_resync();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
